// File: rtl/argmax_stream.sv
// Streaming argmax over one score vector per inference: tracks the running max and runner-up
// and reports the winning class, its score and the top-1/top-2 margin.
module argmax_stream #(
    parameter int NUM_CLASSES = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int IDX_WIDTH   = 4,
    parameter bit SIGNED      = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_WIDTH-1:0]  out_index,
    output logic [DATA_WIDTH-1:0] out_value,
    output logic [DATA_WIDTH:0]   out_margin,
    output logic                  out_err,
    output logic                  busy
);

    localparam int EXT_W = DATA_WIDTH + 1;
    localparam logic [IDX_WIDTH-1:0]  LAST_IDX = IDX_WIDTH'(NUM_CLASSES - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL  =
        SIGNED ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {DATA_WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DONE
    } state_t;

    // One extra bit lets both signed and unsigned scores compare as signed values.
    function automatic logic signed [EXT_W-1:0] ext(input logic [DATA_WIDTH-1:0] v);
        ext = SIGNED ? $signed({v[DATA_WIDTH-1], v}) : $signed({1'b0, v});
    endfunction

    function automatic logic gt(input logic [DATA_WIDTH-1:0] a,
                                input logic [DATA_WIDTH-1:0] b);
        gt = ext(a) > ext(b);
    endfunction

    function automatic logic [EXT_W-1:0] margin(input logic [DATA_WIDTH-1:0] hi,
                                                input logic [DATA_WIDTH-1:0] lo);
        logic signed [EXT_W-1:0] diff;
        diff   = ext(hi) - ext(lo);
        margin = diff;
    endfunction

    state_t                  state_q, state_d;
    logic [IDX_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   max_q, max_d;
    logic [DATA_WIDTH-1:0]   sec_q, sec_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic [IDX_WIDTH-1:0]    out_idx_q, out_idx_d;
    logic [DATA_WIDTH-1:0]   out_val_q, out_val_d;
    logic [EXT_W-1:0]        out_mar_q, out_mar_d;
    logic                    out_err_q, out_err_d;

    logic beat;
    logic last_beat;

    assign beat      = in_valid && (state_q == S_ACCUM);
    assign last_beat = beat && (cnt_q == LAST_IDX);

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready = 1'b1;
                if (last_beat) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        err_d     = err_q;
        max_d     = max_q;
        sec_d     = sec_q;
        idx_d     = idx_q;
        out_idx_d = out_idx_q;
        out_val_d = out_val_q;
        out_mar_d = out_mar_q;
        out_err_d = out_err_q;

        if ((state_q == S_IDLE) && start) begin
            cnt_d = '0;
            err_d = 1'b0;
            max_d = MIN_VAL;
            sec_d = MIN_VAL;
            idx_d = '0;
        end

        if (beat) begin
            cnt_d = cnt_q + 1'b1;
            // in_last must coincide exactly with the final beat; anything else flags the vector.
            err_d = err_q | (in_last != (cnt_q == LAST_IDX));
            if (cnt_q == '0) begin
                max_d = in_data;
                sec_d = MIN_VAL;
                idx_d = '0;
            end else if (gt(in_data, max_q)) begin
                sec_d = max_q;
                max_d = in_data;
                idx_d = cnt_q;
            end else if (gt(in_data, sec_q)) begin
                sec_d = in_data;
            end
        end

        // Result registers load from the post-update trackers so the final beat is included.
        if (last_beat) begin
            out_idx_d = idx_d;
            out_val_d = max_d;
            out_mar_d = margin(max_d, sec_d);
            out_err_d = err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            out_idx_q <= '0;
            out_val_q <= '0;
            out_mar_q <= '0;
            out_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            out_idx_q <= out_idx_d;
            out_val_q <= out_val_d;
            out_mar_q <= out_mar_d;
            out_err_q <= out_err_d;
        end
    end

    // Trackers are always reinitialised by start, so they carry no reset.
    always_ff @(posedge clk) begin
        max_q <= max_d;
        sec_q <= sec_d;
        idx_q <= idx_d;
    end

    assign out_index  = out_idx_q;
    assign out_value  = out_val_q;
    assign out_margin = out_mar_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_argmax_stream.sv
// Scoreboard bench: a signed and an unsigned argmax_stream share one stimulus stream.
module tb_argmax_stream;

    localparam int NC = 10;
    localparam int DW = 16;
    localparam int IW = 4;

    typedef logic [DW-1:0] vec_t [NC];
    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] val;
        logic [DW:0]   mar;
        logic          err;
    } exp_t;

    logic          clk, rst_n, start, in_valid, in_last, out_ready;
    logic [DW-1:0] in_data;

    logic          s_in_ready, s_out_valid, s_err, s_busy;
    logic [IW-1:0] s_idx;
    logic [DW-1:0] s_val;
    logic [DW:0]   s_mar;
    logic          u_in_ready, u_out_valid, u_err, u_busy;
    logic [IW-1:0] u_idx;
    logic [DW-1:0] u_val;
    logic [DW:0]   u_mar;

    int total = 0;
    int bad   = 0;
    exp_t q_s[$];
    exp_t q_u[$];

    argmax_stream #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .SIGNED(1'b1)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(s_out_valid), .out_ready(out_ready),
        .out_index(s_idx), .out_value(s_val), .out_margin(s_mar), .out_err(s_err), .busy(s_busy)
    );

    argmax_stream #(.NUM_CLASSES(NC), .DATA_WIDTH(DW), .IDX_WIDTH(IW), .SIGNED(1'b0)) dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(u_in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(u_out_valid), .out_ready(out_ready),
        .out_index(u_idx), .out_value(u_val), .out_margin(u_mar), .out_err(u_err), .busy(u_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: argmax with lowest index on ties; runner-up is the max of every other entry.
    function automatic exp_t model(input vec_t sc, input bit sgn, input int last_pos);
        exp_t   e;
        longint v[NC];
        longint sec;
        int     best;
        for (int i = 0; i < NC; i++)
            v[i] = sgn ? longint'($signed(sc[i])) : longint'({48'd0, sc[i]});
        best = 0;
        for (int i = 1; i < NC; i++)
            if (v[i] > v[best]) best = i;
        sec = -(longint'(1) << 40);
        for (int i = 0; i < NC; i++)
            if (i != best && v[i] > sec) sec = v[i];
        e.idx = IW'(best);
        e.val = sc[best];
        e.mar = (DW+1)'(v[best] - sec);
        e.err = (last_pos != NC - 1);
        return e;
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (s_out_valid && out_ready) begin
                chk("sb_s_nonempty", q_s.size() != 0, 1);
                if (q_s.size() != 0) begin
                    e = q_s.pop_front();
                    chk("s_index", s_idx, e.idx);
                    chk("s_value", s_val, e.val);
                    chk("s_margin", s_mar, e.mar);
                    chk("s_err", s_err, e.err);
                end
            end
            if (u_out_valid && out_ready) begin
                chk("sb_u_nonempty", q_u.size() != 0, 1);
                if (q_u.size() != 0) begin
                    e = q_u.pop_front();
                    chk("u_index", u_idx, e.idx);
                    chk("u_value", u_val, e.val);
                    chk("u_margin", u_mar, e.mar);
                    chk("u_err", u_err, e.err);
                end
            end
        end
    end

    task automatic run_vec(input vec_t sc, input int last_pos, input bit gaps, input int hold,
                           input bit start_in_done, input int abort_after);
        exp_t es;
        int   k;
        int   guard;
        bit   acc;
        es = model(sc, 1'b1, last_pos);
        if (abort_after < 0) begin
            q_s.push_back(es);
            q_u.push_back(model(sc, 1'b0, last_pos));
        end
        out_ready = (hold == 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("accum_ready", s_in_ready, 1);
        k = 0;
        guard = 0;
        while (k < NC && guard < 500) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = sc[k];
                in_last  = (k == last_pos);
            end
            acc = in_valid && s_in_ready;
            if (acc && k == NC - 1) chk("pre_valid", s_out_valid, 0);
            @(negedge clk);
            guard++;
            if (acc) begin
                k++;
                if (abort_after >= 0 && k == abort_after + 1) break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("beat_budget", guard < 500, 1);

        if (abort_after >= 0) begin
            #2;
            rst_n = 1'b0;
            #1;
            chk("rst_valid", s_out_valid, 0);
            chk("rst_ready", s_in_ready, 0);
            chk("rst_busy", s_busy, 0);
            chk("rst_index", s_idx, 0);
            chk("rst_value", s_val, 0);
            chk("rst_margin", s_mar, 0);
            chk("rst_err", s_err, 0);
            @(negedge clk);
            rst_n = 1'b1;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                chk("abort_no_valid", s_out_valid, 0);
                chk("abort_idle", s_busy, 0);
            end
            return;
        end

        chk("lat_valid_s", s_out_valid, 1);
        chk("lat_valid_u", u_out_valid, 1);
        chk("done_ready", s_in_ready, 0);
        for (int c = 0; c < hold; c++) begin
            if (c == hold / 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk("hold_valid", s_out_valid, 1);
            chk("hold_ready", s_in_ready, 0);
            chk("hold_index", s_idx, es.idx);
            chk("hold_value", s_val, es.val);
            chk("hold_margin", s_mar, es.mar);
        end
        out_ready = 1'b1;
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("post_valid", s_out_valid, 0);
        chk("post_busy", s_busy, 0);
        chk("post_ready", s_in_ready, 0);
    endtask

    initial begin
        vec_t v_basic, v_tie, v_neg, v_uns, v_bnd, v_rnd;
        rst_n     = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        v_basic = '{16'd5, 16'hFFFD, 16'd12, 16'd7, 16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd11};
        v_tie   = '{16'd9, 16'd9, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1};
        v_neg   = '{16'hFFF6, 16'hFFEC, 16'hFFFB, 16'hFFE2, 16'hFFD8,
                    16'hFFCE, 16'hFFC4, 16'hFFBA, 16'hFFB0, 16'hFFA6};
        v_uns   = '{16'd3, 16'd1, 16'd4, 16'd1, 16'd5, 16'd9, 16'd2, 16'hFFFF, 16'd6, 16'd5};
        v_bnd   = '{16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
                    16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000};

        repeat (2) @(negedge clk);
        chk("reset_valid", s_out_valid, 0);
        chk("reset_ready", s_in_ready, 0);
        chk("reset_busy", s_busy, 0);
        chk("reset_index", s_idx, 0);
        chk("reset_value", s_val, 0);
        chk("reset_margin", s_mar, 0);
        chk("reset_err", s_err, 0);
        rst_n = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd77;
        @(negedge clk);
        chk("idle_ready", s_in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle_busy", s_busy, 0);

        run_vec(v_basic, 9, 1'b0, 0, 1'b0, -1);
        run_vec(v_tie, 9, 1'b0, 0, 1'b0, -1);
        run_vec(v_neg, 9, 1'b0, 0, 1'b0, -1);
        run_vec(v_uns, 9, 1'b0, 0, 1'b0, -1);
        run_vec(v_basic, 9, 1'b1, 0, 1'b0, -1);
        run_vec(v_basic, 9, 1'b0, 20, 1'b0, -1);
        run_vec(v_bnd, 9, 1'b1, 3, 1'b1, -1);
        run_vec(v_tie, 4, 1'b0, 0, 1'b0, -1);
        run_vec(v_neg, -1, 1'b0, 0, 1'b0, -1);
        run_vec(v_basic, 9, 1'b0, 0, 1'b1, -1);
        run_vec(v_basic, 9, 1'b0, 0, 1'b0, 5);
        run_vec(v_basic, 9, 1'b0, 0, 1'b0, -1);
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < NC; i++) v_rnd[i] = DW'($urandom);
            run_vec(v_rnd, 9, 1'b1, r, 1'b0, -1);
        end

        repeat (3) @(negedge clk);
        chk("sb_s_drained", q_s.size(), 0);
        chk("sb_u_drained", q_u.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/argmax_stream.md
Name: argmax_stream

Overview:
- Sequential, handshaked successor to the combinational argmax at the classifier output.
- Accepts one class score per beat from the final dense layer and tracks the running maximum and runner-up.
- After the last class it emits the predicted index, the winning score and a top-1/top-2 margin for confidence gating.
- Generalised in class count, score width and signedness.

Parameters:
- NUM_CLASSES, 10: scores per inference; legal range 2 to 2^IDX_WIDTH.
- DATA_WIDTH, 16: width of each score.
- IDX_WIDTH, 4: width of class index outputs.
- SIGNED, 1: 1 = scores are two's complement; 0 = unsigned.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a new inference, honoured only in IDLE.
- in_valid  in  1  score beat valid.
- in_ready  out  1  block can accept a score.
- in_data  in  DATA_WIDTH  class score; class index is the beat order.
- in_last  in  1  producer marks the final score of the vector.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts result.
- out_index  out  IDX_WIDTH  predicted class.
- out_value  out  DATA_WIDTH  winning score.
- out_margin  out  DATA_WIDTH+1  unsigned max minus second-max.
- out_err  out  1  in_last was misplaced in this vector.
- busy  out  1  high outside IDLE.

Behaviour:
- Reset (async assert, sync release): state IDLE. in_ready, out_valid, out_err and busy are 0. out_index, out_value and out_margin are 0. Internal count is 0.
- A reset during an inference abandons it; no partial result is ever emitted.
- FSM states: IDLE, ACCUM, DONE.
- IDLE: start=1 moves to ACCUM next cycle and clears the count, the sticky error and the trackers. Score beats arriving in IDLE are not accepted because in_ready=0.
- ACCUM: in_ready=1. A beat is accepted when in_valid and in_ready are both high. Accepted beat number k (0-based) is class k.
- Beat 0: max=in_data, max_idx=0, second=the minimum representable value (0x8000 when SIGNED=1 at default width; 0 when SIGNED=0).
- Beat k>0, in order:
  - If in_data > max (strictly greater): second=max, max=in_data, max_idx=k.
  - Else if in_data > second: second=in_data.
- Ties: the lower index wins. A score equal to max replaces second, so the margin becomes 0.
- Comparisons are signed or unsigned per SIGNED.
- out_err is set (sticky for this vector) in two cases:
  - in_last=1 on any beat other than beat NUM_CLASSES-1.
  - in_last=0 on beat NUM_CLASSES-1.
- Early in_last does not terminate accumulation. Exactly NUM_CLASSES beats are always consumed.
- After beat NUM_CLASSES-1 is accepted: state becomes DONE, in_ready drops the same edge, and out_valid=1 on the next cycle. Latency from last accepted beat to out_valid is 1 cycle.
- DONE: out_index=max_idx, out_value=max, out_margin=max-second computed at DATA_WIDTH+1 bits (always ≥ 0). These outputs and out_valid are stable until out_valid and out_ready are both high. On acceptance the state returns to IDLE and out_valid=0 the next cycle.
- Outputs keep their last value in IDLE. start during ACCUM or DONE is ignored.
- start in the same cycle as the DONE handshake is ignored. A new start is required in IDLE.
- Back-to-back inferences: the minimum gap is one IDLE cycle with start.
- in_valid gaps in ACCUM are allowed; the count holds across them.
- No simulation-only display statements in synthesizable code.

Test Plan:
- Basic case: SIGNED=1; scores 5,-3,12,7,0,1,2,3,4,11, in_last on beat 9, out_ready=1. Expect out_index=2, out_value=12, out_margin=1, out_err=0, and out_valid exactly 1 cycle after beat 9.
- Tie: scores 9,9,1,1,1,1,1,1,1,1. Expect out_index=0, out_value=9, out_margin=0.
- All negative with SIGNED=1: scores -10,-20,-5,-30,-40,-50,-60,-70,-80,-90. Expect out_index=2, out_margin=5. With SIGNED=0 and 0xFFFF on beat 7 (other beats small), expect out_index=7.
- Backpressure and gaps:
  - Random in_valid gaps during accumulation must give a result identical to the first case.
  - Hold out_ready=0 for 20 cycles: out_valid and outputs stay stable and in_ready stays 0.
  - A start pulse during DONE is ignored.
- Framing error: in_last on beat 4 gives out_err=1 with 10 beats still consumed. The next clean vector gives out_err=0.
- Reset mid-vector: assert rst_n=0 after beat 5. Outputs go to 0 asynchronously and out_valid never rises. A subsequent full vector produces the correct result.
